flash_read_responder: RTL
=========================

FLASH_READ_RESPONDER -- requirements
Module: flash_read_responder

Interface
REQ-001 Parameter: ADDR_W, default 23, word-address width of request and backing-store port.
REQ-002 Parameter: READ_LATENCY, default 2, edges from request acceptance to response; legal 2..8.
REQ-003 Parameter: MAX_PENDING, default 4, maximum in-flight requests; legal 1..8.
REQ-004 sample_clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset, sampled on sample_clk.
REQ-006 flash_mem_read  in  1  read request from the read master.
REQ-007 flash_mem_address  in  ADDR_W  word address qualified by flash_mem_read.
REQ-008 flash_mem_waitrequest  out  1  high = request not accepted this edge.
REQ-009 flash_mem_readdatavalid  out  1  one-edge pulse marking a valid response.
REQ-010 flash_mem_readdata  out  32  response word.
REQ-011 rom_addr  out  ADDR_W  backing-store address, combinationally equal to flash_mem_address.
REQ-012 rom_rden  out  1  backing-store read enable, combinationally equal to the accept condition.
REQ-013 rom_q  in  32  backing-store data, valid one edge after rom_rden.

Function
REQ-014 Accept condition: flash_mem_read=1 and flash_mem_waitrequest=0 at a rising edge.
REQ-015 flash_mem_waitrequest = 1 when pending count equals MAX_PENDING or reset=1; else 0 (combinational from registers and reset only).
REQ-016 Request accepted at edge N produces flash_mem_readdatavalid=1 for exactly the cycle following edge N+READ_LATENCY-1, with flash_mem_readdata = rom_q data for that address.
REQ-017 Responses returned strictly in acceptance order; one response per accepted request; back-to-back accepts yield back-to-back responses.
REQ-018 Internal valid/data delay line of READ_LATENCY-1 stages after the ROM stage; no flow control on the response side (master always accepts).
REQ-019 Pending count: +1 on accept, -1 on response issue; simultaneous accept and response leaves count unchanged; never exceeds MAX_PENDING nor underflows.
REQ-020 State machine: IDLE (count=0), ACTIVE (0<count<MAX_PENDING), FULL (count=MAX_PENDING); transitions follow count each edge; FULL->ACTIVE on response without accept.
REQ-021 flash_mem_readdata holds last response value while flash_mem_readdatavalid=0.
REQ-022 flash_mem_read with waitrequest=1 is ignored; master must hold request; address change while stalled is legal, last value at accept edge is used.
REQ-023 Address is used as-is, ADDR_W bits; no range check; all-ones address is a legal read.

Reset
REQ-024 While reset=1: count=0, state IDLE, all delay-line valid bits 0, flash_mem_readdatavalid=0, flash_mem_readdata=32'h0, rom_rden=0.
REQ-025 Reset mid-operation discards all in-flight requests; no flash_mem_readdatavalid for them after reset deasserts.
REQ-026 First request may be accepted at the first edge with reset=0.

Configuration
REQ-027 Macro FLASH_RESP_BYTESWAP_EN: when defined, flash_mem_readdata = rom_q with byte order reversed ({b0,b1,b2,b3}); when undefined, rom_q passes unmodified; latency identical in both builds.

Verification
REQ-028 Single read addr 0x000010, rom_q=0xA1B2C3D4, READ_LATENCY=2 -> one readdatavalid pulse 2 edges after accept, readdata=0xA1B2C3D4 (0xD4C3B2A1 with FLASH_RESP_BYTESWAP_EN).
REQ-029 flash_mem_read held high 10 edges, addrs 0..9, MAX_PENDING=4, READ_LATENCY=2 -> 10 consecutive valid pulses, data in address order, waitrequest never 1.
REQ-030 MAX_PENDING=1, READ_LATENCY=4, continuous read -> waitrequest=1 for 3 of every 4 edges, one response per 4 edges, in order.
REQ-031 Reset asserted 1 edge after accepting 3 requests -> zero readdatavalid pulses thereafter, readdata=0x0, waitrequest=0 after reset release.
REQ-032 Accept coincident with response at count=MAX_PENDING-1 -> count unchanged, state ACTIVE, no dropped or duplicated response.
REQ-033 Read addr 0x7FFFFF (all-ones, ADDR_W=23) -> rom_addr=0x7FFFFF, response returned normally.

Source files
------------

// File: rtl/flash_read_responder_if.sv
// flash_read_responder_if: read-master request/response signals plus the backing-store port.
interface flash_read_responder_if #(
    parameter int ADDR_W = 23
);
    logic              flash_mem_read;
    logic [ADDR_W-1:0] flash_mem_address;
    logic              flash_mem_waitrequest;
    logic              flash_mem_readdatavalid;
    logic [31:0]       flash_mem_readdata;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_rden;
    logic [31:0]       rom_q;

    modport slave (
        input  flash_mem_read, flash_mem_address, rom_q,
        output flash_mem_waitrequest, flash_mem_readdatavalid, flash_mem_readdata, rom_addr, rom_rden
    );

    modport master (
        output flash_mem_read, flash_mem_address, rom_q,
        input  flash_mem_waitrequest, flash_mem_readdatavalid, flash_mem_readdata, rom_addr, rom_rden
    );
endinterface

// File: rtl/flash_read_responder.sv
// flash_read_responder: fixed-latency in-order read responder in front of a one-cycle ROM.
// Define FLASH_RESP_BYTESWAP_EN to return each ROM word with its byte order reversed.
module flash_read_responder #(
    parameter int ADDR_W       = 23,
    parameter int READ_LATENCY = 2,
    parameter int MAX_PENDING  = 4
) (
    input logic sample_clk,
    input logic reset,
    flash_read_responder_if.slave bus
);
    localparam int CW = $clog2(MAX_PENDING + 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, FULL} state_t;

    state_t                  state, state_nx;
    logic [CW-1:0]           count, count_nx;
    logic [READ_LATENCY-1:0] vld;
    logic [31:0]             dat [1:READ_LATENCY-1];
    logic [31:0]             rom_word;
    logic                    accept, issue;

`ifdef FLASH_RESP_BYTESWAP_EN
    assign rom_word = {bus.rom_q[7:0], bus.rom_q[15:8], bus.rom_q[23:16], bus.rom_q[31:24]};
`else
    assign rom_word = bus.rom_q;
`endif

    assign bus.flash_mem_waitrequest   = reset || state == FULL;
    assign accept                      = bus.flash_mem_read && !bus.flash_mem_waitrequest;
    assign issue                       = vld[READ_LATENCY-2];
    assign bus.rom_rden                = accept;
    assign bus.rom_addr                = ADDR_W'(bus.flash_mem_address);
    assign bus.flash_mem_readdatavalid = vld[READ_LATENCY-1] && !reset;
    assign bus.flash_mem_readdata      = reset ? '0 : dat[READ_LATENCY-1];

    // A response leaves the pending set on the edge that loads the output stage.
    always_comb begin
        count_nx = (accept && !issue) ? count + CW'(1) : (issue && !accept) ? count - CW'(1) : count;
        state_nx = count_nx == '0 ? IDLE : count_nx == CW'(MAX_PENDING) ? FULL : ACTIVE;
    end

    always_ff @(posedge sample_clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nx;
            count <= count_nx;
        end
    end

    // vld[0] tracks the ROM stage; stages 1..READ_LATENCY-1 carry data, the last one holds the output.
    always_ff @(posedge sample_clk) begin
        if (reset) begin
            vld <= '0;
            for (int i = 1; i < READ_LATENCY; i++) dat[i] <= '0;
        end else begin
            vld <= {vld[READ_LATENCY-2:0], accept};
            if (vld[0]) dat[1] <= rom_word;
            for (int i = READ_LATENCY - 1; i >= 2; i--) if (vld[i-1]) dat[i] <= dat[i-1];
        end
    end
endmodule
